// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the 64-channel TDM demultiplexer.
// Contents:
//   N_CH_DEFAULT - default channel count per frame
//   sel_w()      - slot index width for a given channel count
//   slot_t       - slot index type at the default channel count
package tdm_demux_pkg;

    localparam int unsigned N_CH_DEFAULT = 64;

    // Channel count is a power of two and at least 2, so this is never 0.
    function automatic int unsigned sel_w(input int unsigned n_ch);
        return $clog2(n_ch);
    endfunction

    typedef logic [sel_w(N_CH_DEFAULT)-1:0] slot_t;

endpackage

// File: rtl/tdm_demux64_if.sv
// Bus interface of the TDM demultiplexer: serial input side, parallel output
// handshake, error flags and their clear.
// Signals:
//   in_valid, in_bit, in_sof   - serial bit stream with start-of-frame marker
//   out_ready                  - downstream accepts out_data
//   clr_err                    - synchronous clear of sticky flags
//   out_data, out_valid        - assembled frame and its valid
//   slot                       - slot the next accepted bit will occupy
//   overflow, frame_err        - sticky error flags
// Modports: master drives the inputs (source/sink side), slave is the demux.
interface tdm_demux64_if
    import tdm_demux_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEFAULT
);
    localparam int unsigned SEL_W = sel_w(N_CH);

    logic             in_valid;
    logic             in_bit;
    logic             in_sof;
    logic             out_ready;
    logic             clr_err;
    logic [N_CH-1:0]  out_data;
    logic             out_valid;
    logic [SEL_W-1:0] slot;
    logic             overflow;
    logic             frame_err;

    modport master (
        output in_valid, in_bit, in_sof, out_ready, clr_err,
        input  out_data, out_valid, slot, overflow, frame_err
    );

    modport slave (
        input  in_valid, in_bit, in_sof, out_ready, clr_err,
        output out_data, out_valid, slot, overflow, frame_err
    );

endinterface

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer. Tracks which channel slot the next
// accepted bit lands in, resolves start-of-frame into an effective slot,
// flags first/last slot of a frame and raises a sticky frame error when a
// start-of-frame arrives mid-frame.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - a bit is accepted this cycle
//   in_sof      - start of frame, qualified by in_valid
//   clr_err     - clear frame_err (a simultaneous set wins)
//   slot        - registered slot for the next accepted bit
//   s_eff       - slot the current bit occupies (0 on start of frame)
//   first, last - current accept is slot 0 / slot N_CH-1
//   frame_err   - sticky: in_sof seen with slot != 0
module tdm_slot_ctr
    import tdm_demux_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEFAULT,
    localparam int unsigned SEL_W = sel_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             clr_err,
    output logic [SEL_W-1:0] slot,
    output logic [SEL_W-1:0] s_eff,
    output logic             first,
    output logic             last,
    output logic             frame_err
);

    localparam logic [SEL_W-1:0] LastSlot = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0] slot_q, slot_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        s_eff       = (in_valid && in_sof) ? '0 : slot_q;
        first       = in_valid && (s_eff == '0);
        last        = in_valid && (s_eff == LastSlot);
        // N_CH is a power of two, so the natural carry-out gives the wrap.
        slot_d      = in_valid ? s_eff + SEL_W'(1) : slot_q;
        frame_err_d = clr_err ? 1'b0 : frame_err_q;
        if (in_valid && in_sof && (slot_q != '0)) begin
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign slot      = slot_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/tdm_demux64.sv
// Time-division demultiplexer: collects one serial bit per valid cycle into
// the slot chosen by an auto-incrementing counter, assembles a full frame in
// a shadow register and hands it to a single-entry valid/ready output buffer.
// A completed frame that meets a blocked buffer is dropped (sticky overflow).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of tdm_demux64_if (serial in, frame out, flags)
module tdm_demux64
    import tdm_demux_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEFAULT
) (
    input logic           clk,
    input logic           rst_n,
    tdm_demux64_if.slave  bus
);

    localparam int unsigned SEL_W = sel_w(N_CH);

    logic [SEL_W-1:0] s_eff;
    logic             first;
    logic             last;

    tdm_slot_ctr #(
        .N_CH (N_CH)
    ) u_slot_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_sof    (bus.in_sof),
        .clr_err   (bus.clr_err),
        .slot      (bus.slot),
        .s_eff     (s_eff),
        .first     (first),
        .last      (last),
        .frame_err (bus.frame_err)
    );

    logic [N_CH-1:0] shadow_q, shadow_d;
    logic [N_CH-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            overflow_q, overflow_d;
    logic [N_CH-1:0] frame;

    always_comb begin
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = bus.clr_err ? 1'b0 : overflow_q;

        // Completed frame: shadow with the final bit merged in.
        frame           = shadow_q;
        frame[N_CH-1]   = bus.in_bit;

        if (bus.in_valid) begin
            if (first) begin
                // A fresh or restarted frame must not inherit stale bits.
                shadow_d    = '0;
                shadow_d[0] = bus.in_bit;
            end else begin
                shadow_d[s_eff] = bus.in_bit;
            end
        end

        if (last) begin
            if (!out_valid_q || bus.out_ready) begin
                out_data_d  = frame;
                out_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = overflow_q;

endmodule
